// File: rtl/bytecode_loader_pkg.sv
// Shared opcode constants and parser state type for the bytecode loader.
// The CSUM state exists only when BYTECODE_LOADER_CHECKSUM_EN is defined.
package bytecode_loader_pkg;

    localparam logic [7:0] OPC_TWO = 8'h02;
    localparam logic [7:0] OPC_ONE = 8'h01;
    localparam logic [7:0] OPC_END = 8'hFF;

    typedef enum logic [2:0] {
        StOpc,
        StOpr,
        StArg1,
        StArg2,
`ifdef BYTECODE_LOADER_CHECKSUM_EN
        StCsum,
`endif
        StDone,
        StErr
    } state_t;

endpackage

// File: rtl/bytecode_loader.sv
// Streams framed bytecode into program memory, one byte per cycle, with framing/overflow checks.
// Optional trailing XOR checksum byte is enabled by defining BYTECODE_LOADER_CHECKSUM_EN.
module bytecode_loader
    import bytecode_loader_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W-1:0] instr_count
);

    // One extra bit so a terminator written at the top address cannot wrap the counter.
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(MEM_DEPTH - 1);

    state_t            r_state, w_state_next;
    logic              r_two, w_two_next;
    logic [ADDR_W:0]   r_addr, w_addr_next;
    logic [ADDR_W-1:0] r_count, w_count_next;
    logic              r_wr_en, w_wr_en_next;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_next;
    logic [7:0]        r_wr_data, w_wr_data_next;
    logic              w_xfer;
    logic              w_write;
    logic              w_frame_end;
`ifdef BYTECODE_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum, w_csum_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StOpc;
            r_two     <= 1'b0;
            r_addr    <= '0;
            r_count   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'h00;
`ifdef BYTECODE_LOADER_CHECKSUM_EN
            r_csum    <= 8'h00;
`endif
        end else begin
            r_state   <= w_state_next;
            r_two     <= w_two_next;
            r_addr    <= w_addr_next;
            r_count   <= w_count_next;
            r_wr_en   <= w_wr_en_next;
            r_wr_addr <= w_wr_addr_next;
            r_wr_data <= w_wr_data_next;
`ifdef BYTECODE_LOADER_CHECKSUM_EN
            r_csum    <= w_csum_next;
`endif
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_two_next     = r_two;
        w_addr_next    = r_addr;
        w_count_next   = r_count;
        w_wr_en_next   = 1'b0;
        w_wr_addr_next = r_wr_addr;
        w_wr_data_next = r_wr_data;
        w_write        = 1'b0;
        w_frame_end    = 1'b0;
`ifdef BYTECODE_LOADER_CHECKSUM_EN
        w_csum_next    = r_csum;
`endif
        in_ready   = (r_state != StDone) && (r_state != StErr);
        load_done  = (r_state == StDone);
        load_error = (r_state == StErr);
        w_xfer     = in_valid && in_ready;

        if (w_xfer) begin
            case (r_state)
                StOpc: begin
                    if (in_data == OPC_TWO) begin
                        w_state_next = StOpr;
                        w_two_next   = 1'b1;
                        w_write      = 1'b1;
                    end else if (in_data == OPC_ONE) begin
                        w_state_next = StOpr;
                        w_two_next   = 1'b0;
                        w_write      = 1'b1;
                    end else if (in_data == OPC_END) begin
                        w_write      = 1'b1;
                        w_frame_end  = 1'b1;
`ifdef BYTECODE_LOADER_CHECKSUM_EN
                        w_state_next = StCsum;
`else
                        w_state_next = StDone;
`endif
                    end else begin
                        w_state_next = StErr;
                    end
                end
                StOpr: begin
                    w_state_next = StArg1;
                    w_write      = 1'b1;
                end
                StArg1: begin
                    w_write = 1'b1;
                    if (r_two) begin
                        w_state_next = StArg2;
                    end else begin
                        w_state_next = StOpc;
                        w_frame_end  = 1'b1;
                    end
                end
                StArg2: begin
                    w_state_next = StOpc;
                    w_write      = 1'b1;
                    w_frame_end  = 1'b1;
                end
`ifdef BYTECODE_LOADER_CHECKSUM_EN
                StCsum: begin
                    w_state_next = (in_data == r_csum) ? StDone : StErr;
                end
`endif
                default: begin
                end
            endcase

            // Only a terminator may occupy the last memory location.
            if (w_write && (r_addr == LAST_ADDR) &&
                !((r_state == StOpc) && (in_data == OPC_END))) begin
                w_write      = 1'b0;
                w_frame_end  = 1'b0;
                w_state_next = StErr;
            end

            if (w_write) begin
                w_wr_en_next   = 1'b1;
                w_wr_addr_next = r_addr[ADDR_W-1:0];
                w_wr_data_next = in_data;
                w_addr_next    = r_addr + (ADDR_W+1)'(1);
`ifdef BYTECODE_LOADER_CHECKSUM_EN
                w_csum_next    = r_csum ^ in_data;
`endif
            end
            if (w_frame_end) begin
                w_count_next = r_count + ADDR_W'(1);
            end
        end

        if (restart && ((r_state == StDone) || (r_state == StErr))) begin
            w_state_next   = StOpc;
            w_two_next     = 1'b0;
            w_addr_next    = '0;
            w_count_next   = '0;
            w_wr_en_next   = 1'b0;
            w_wr_addr_next = '0;
            w_wr_data_next = 8'h00;
`ifdef BYTECODE_LOADER_CHECKSUM_EN
            w_csum_next    = 8'h00;
`endif
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign instr_count = r_count;

endmodule

// File: tb/tb_bytecode_loader.sv
// Self-checking bench for bytecode_loader: directed and random streams against a frame-level model.
// Honours BYTECODE_LOADER_CHECKSUM_EN by appending checksum bytes to terminated streams.
module tb_bytecode_loader;

    localparam int DEPTH = 1024;

    logic       clk;
    logic       reset;
    logic       restart;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       load_done;
    logic       load_error;
    logic [9:0] instr_count;

    bytecode_loader #(
        .MEM_DEPTH(DEPTH),
        .ADDR_W   (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .load_done  (load_done),
        .load_error (load_error),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level reference: bytes left in current frame, next offset, counters.
    int         m_rem;
    int         m_addr;
    int         m_count;
    logic [7:0] m_xor;
    bit         m_done;
    bit         m_err;
    bit         m_csum_wait;
    bit         exp_wr;
    int         exp_addr;
    logic [7:0] exp_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_restart();
        m_rem = 0; m_addr = 0; m_count = 0; m_xor = 8'h00;
        m_done = 0; m_err = 0; m_csum_wait = 0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        int len;
        bit is_op;
        len = 0;
        if (m_csum_wait) begin
            m_csum_wait = 0;
            if (b == m_xor) m_done = 1; else m_err = 1;
            return;
        end
        is_op = (m_rem == 0);
        if (is_op) begin
            case (b)
                8'h02:   len = 4;
                8'h01:   len = 3;
                8'hFF:   len = 1;
                default: len = 0;
            endcase
            if (len == 0) begin
                m_err = 1;
                return;
            end
        end
        if (m_addr == DEPTH - 1 && !(is_op && b == 8'hFF)) begin
            m_err = 1;
            return;
        end
        exp_wr = 1; exp_addr = m_addr; exp_data = b;
        m_addr++;
        m_xor ^= b;
        m_rem = is_op ? len - 1 : m_rem - 1;
        if (m_rem == 0) begin
            m_count++;
            if (is_op && b == 8'hFF) begin
`ifdef BYTECODE_LOADER_CHECKSUM_EN
                m_csum_wait = 1;
`else
                m_done = 1;
`endif
            end
        end
    endtask

    // One clock cycle of stimulus with full output check one cycle later.
    task automatic step(input logic v, input logic [7:0] d, input logic rs);
        bit pre_stop;
        bit xfer;
        in_valid = v; in_data = d; restart = rs;
        pre_stop = m_done || m_err;
        #1;
        chk("in_ready", in_ready, !pre_stop);
        xfer = v && !pre_stop;
        @(posedge clk);
        exp_wr = 0;
        if (xfer) model_accept(d);
        if (rs && pre_stop) model_restart();
        #1;
        chk("wr_en", wr_en, exp_wr);
        if (exp_wr) begin
            chk("wr_addr", wr_addr, exp_addr);
            chk("wr_data", wr_data, exp_data);
        end
        chk("load_done", load_done, m_done);
        chk("load_error", load_error, m_err);
        chk("instr_count", instr_count, m_count);
    endtask

    task automatic send(input logic [7:0] b, input bit gaps);
        int idle;
        idle = gaps ? int'($urandom_range(0, 2)) : 0;
        repeat (idle) step(1'b0, 8'($urandom), 1'b0);
        step(1'b1, b, 1'b0);
    endtask

    task automatic send_csum(input bit ok);
`ifdef BYTECODE_LOADER_CHECKSUM_EN
        if (m_csum_wait) step(1'b1, ok ? m_xor : (m_xor ^ 8'h5A), 1'b0);
`else
        if (ok) begin end
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h02; restart = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0;
        model_restart();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_error", load_error, 0);
        chk("rst_instr_count", instr_count, 0);
    endtask

    initial begin
        logic [7:0] s033 [5];
        logic [7:0] s034 [4];
        logic [7:0] b;

        reset = 1'b1; restart = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        model_restart();
        exp_wr = 0; exp_addr = 0; exp_data = 8'h00;
        @(posedge clk);
        #1;
        do_reset();

        // Contiguous two-frame program.
        s033 = '{8'h02, 8'h05, 8'h0A, 8'h03, 8'hFF};
        foreach (s033[i]) send(s033[i], 1'b0);
        send_csum(1'b1);
        chk("t033_done", load_done, 1);
        chk("t033_count", instr_count, 2);
        step(1'b1, 8'h02, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("t033_restart_addr", wr_addr, 0);

        // in_valid toggling every cycle.
        s034 = '{8'h01, 8'h07, 8'h09, 8'hFF};
        foreach (s034[i]) begin
            step(1'b0, 8'($urandom), 1'b0);
            step(1'b1, s034[i], 1'b0);
        end
        send_csum(1'b1);
        chk("t034_count", instr_count, 2);
        step(1'b0, 8'h00, 1'b1);

        // Bad opcode after a full frame; restart mid-frame must be ignored.
        send(8'h02, 1'b0);
        step(1'b1, 8'h05, 1'b1);
        send(8'h7E, 1'b0);
        send(8'h11, 1'b0);
        send(8'h7E, 1'b0);
        chk("t035_error", load_error, 1);
        chk("t035_ready", in_ready, 0);
        step(1'b0, 8'h00, 1'b1);
        chk("t035_restart_addr", wr_addr, 0);
        chk("t035_restart_ready", in_ready, 1);

        // Reset in the middle of a frame.
        send(8'h02, 1'b0);
        send(8'h05, 1'b0);
        do_reset();
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        send(8'hFF, 1'b0);
        send_csum(1'b1);
        chk("t037_done", load_done, 1);
        step(1'b0, 8'h00, 1'b1);

        // Random programs with random gaps and occasional bad opcodes.
        for (int it = 0; it < 10; it++) begin
            int nfr;
            nfr = int'($urandom_range(1, 5));
            for (int f = 0; f < nfr && !m_err; f++) begin
                int kind;
                kind = int'($urandom_range(0, 9));
                if (kind == 0) begin
                    b = 8'($urandom);
                    if (b == 8'h01 || b == 8'h02 || b == 8'hFF) b = 8'h7E;
                    send(b, 1'b1);
                end else begin
                    send(kind < 5 ? 8'h02 : 8'h01, 1'b1);
                    send(8'($urandom), 1'b1);
                    send(8'($urandom), 1'b1);
                    if (kind < 5) send(8'($urandom), 1'b1);
                end
            end
            if (!m_err) begin
                send(8'hFF, 1'b1);
                send_csum($urandom_range(0, 3) != 0);
            end
            step(1'b0, 8'h00, 1'b1);
        end

        // Fill to the last address: a non-terminator there overflows.
        for (int i = 0; i < 341; i++) begin
            send(8'h01, 1'b0);
            send(8'($urandom), 1'b0);
            send(8'($urandom), 1'b0);
        end
        step(1'b1, 8'h01, 1'b0);
        chk("t036_error", load_error, 1);
        step(1'b0, 8'h00, 1'b1);

        // A terminator at the last address is legal.
        for (int i = 0; i < 341; i++) begin
            send(8'h01, 1'b0);
            send(8'($urandom), 1'b0);
            send(8'($urandom), 1'b0);
        end
        send(8'hFF, 1'b0);
        send_csum(1'b1);
        chk("t036_term_done", load_done, 1);
        chk("t036_term_count", instr_count, 342);
        step(1'b0, 8'h00, 1'b1);

`ifdef BYTECODE_LOADER_CHECKSUM_EN
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'hFF, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        chk("t038_good_csum", load_done, 1);
        step(1'b0, 8'h00, 1'b1);
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'hFF, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        chk("t038_bad_csum", load_error, 1);
        step(1'b0, 8'h00, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
